// File: rtl/v_lane_sequencer_pkg.sv
// v_lane_pkg: shared constants, FSM state type and sizing helpers for the
// vector lane sequencer.
//   ELEN          - physical lane width in bits
//   state_t       - sequencer FSM states
//   lmul_to_regs  - group size code -> {legal, registers per group}
//   num_beats     - issue beats needed to cover a register group
package v_lane_pkg;

   localparam int ELEN = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   // Returns {legal, regs[2:0]}; codes 3..7 are illegal.
   function automatic logic [3:0] lmul_to_regs(input logic [2:0] lmul);
      case (lmul)
         3'd0:    return {1'b1, 3'd1};
         3'd1:    return {1'b1, 3'd2};
         3'd2:    return {1'b1, 3'd4};
         default: return {1'b0, 3'd0};
      endcase
   endfunction

   // Beats = ceil(slots / lanes), slots = regs * vlen / ELEN.
   function automatic int num_beats(input int regs, input int lanes, input int vlen = 128);
      int slots;
      slots = regs * vlen / ELEN;
      return (slots + lanes - 1) / lanes;
   endfunction

endpackage

// File: rtl/v_lane_sequencer_slot.sv
// One vector lane: operand slice selection plus the per-lane execution units.
//   v_alu       - 32-bit ALU, SEW-aware add/sub, bitwise ops, LAT register stages
//   v_mul       - 32-bit multiplier, SEW-aware low product / 32-bit high product
//   v_lane_slot - picks slot beat*NUM_LANES+LANE from op_A/op_B (zero when the
//                 slot is outside the current group) and feeds the units.
// Ports (v_lane_slot):
//   clk, nrst        clock, synchronous active-low reset
//   beat, num_slots  current issue beat, slot count of the active group
//   op_alu, vsew     latched ALU opcode and element width
//   op_A, op_B       operand groups
//   res_alu          ALU result, valid UNIT_LAT cycles after presentation
//   op_mul, res_mul  MUL opcode / result, only with V_LANE_SEQ_VMUL_EN
// Build option: V_LANE_SEQ_VMUL_EN adds the v_mul unit and its ports.

module v_alu #(
   parameter int LAT = 1
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [5:0]  op,
   input  logic [2:0]  vsew,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   logic [31:0] f;

   // Element-wise add/sub: carries never cross an element boundary.
   function automatic logic [31:0] ew_addsub(input logic [31:0] x, input logic [31:0] z,
                                             input logic sub, input logic [2:0] sew);
      logic [31:0] r;
      r = '0;
      case (sew)
         3'd0: for (int i = 0; i < 4; i++)
                  r[i*8 +: 8] = sub ? x[i*8 +: 8] - z[i*8 +: 8] : x[i*8 +: 8] + z[i*8 +: 8];
         3'd1: for (int i = 0; i < 2; i++)
                  r[i*16 +: 16] = sub ? x[i*16 +: 16] - z[i*16 +: 16] : x[i*16 +: 16] + z[i*16 +: 16];
         default: r = sub ? x - z : x + z;
      endcase
      return r;
   endfunction

   always_comb begin
      f = a;
      case (op)
         6'd0:    f = ew_addsub(a, b, 1'b0, vsew);
         6'd1:    f = ew_addsub(a, b, 1'b1, vsew);
         6'd2:    f = a & b;
         6'd3:    f = a | b;
         6'd4:    f = a ^ b;
         default: f = a;
      endcase
   end

   if (LAT == 0) begin : g_comb
      logic unused_clk;
      assign unused_clk = clk ^ nrst;
      assign y = f;
   end else begin : g_pipe
      logic [31:0] stg [LAT];
      always_ff @(posedge clk) begin
         if (!nrst) begin
            for (int i = 0; i < LAT; i++) stg[i] <= '0;
         end else begin
            stg[0] <= f;
            for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
         end
      end
      assign y = stg[LAT-1];
   end

endmodule

module v_mul #(
   parameter int LAT = 1
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [5:0]  op,
   input  logic [2:0]  vsew,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   logic [31:0] f;
   logic [63:0] prod;

   function automatic logic [31:0] ew_mul_lo(input logic [31:0] x, input logic [31:0] z,
                                             input logic [2:0] sew);
      logic [31:0] r;
      r = '0;
      case (sew)
         3'd0: for (int i = 0; i < 4; i++) r[i*8 +: 8] = x[i*8 +: 8] * z[i*8 +: 8];
         3'd1: for (int i = 0; i < 2; i++) r[i*16 +: 16] = x[i*16 +: 16] * z[i*16 +: 16];
         default: r = x * z;
      endcase
      return r;
   endfunction

   assign prod = {32'd0, a} * {32'd0, b};

   always_comb begin
      f = '0;
      case (op)
         6'd0:    f = ew_mul_lo(a, b, vsew);
         6'd1:    f = prod[63:32];
         default: f = '0;
      endcase
   end

   if (LAT == 0) begin : g_comb
      logic unused_clk;
      assign unused_clk = clk ^ nrst;
      assign y = f;
   end else begin : g_pipe
      logic [31:0] stg [LAT];
      always_ff @(posedge clk) begin
         if (!nrst) begin
            for (int i = 0; i < LAT; i++) stg[i] <= '0;
         end else begin
            stg[0] <= f;
            for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
         end
      end
      assign y = stg[LAT-1];
   end

endmodule

module v_lane_slot
   import v_lane_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int LANE      = 0,
   parameter int VLEN      = 128,
   parameter int MAX_GROUP = 4,
   parameter int UNIT_LAT  = 1,
   parameter int BW        = 3,
   parameter int SW        = 5
) (
   input  logic                      clk,
   input  logic                      nrst,
   input  logic [BW-1:0]             beat,
   input  logic [SW-1:0]             num_slots,
   input  logic [5:0]                op_alu,
   input  logic [2:0]                vsew,
   input  logic [MAX_GROUP*VLEN-1:0] op_A,
   input  logic [MAX_GROUP*VLEN-1:0] op_B,
   output logic [ELEN-1:0]           res_alu
`ifdef V_LANE_SEQ_VMUL_EN
   ,
   input  logic [5:0]                op_mul,
   output logic [ELEN-1:0]           res_mul
`endif
);

   localparam int TOTAL_SLOTS = MAX_GROUP * VLEN / ELEN;

   int              slot;
   logic [ELEN-1:0] a;
   logic [ELEN-1:0] b;

   // Lanes past the end of the group see zero operands.
   always_comb begin
      slot = int'(beat) * NUM_LANES + LANE;
      a    = '0;
      b    = '0;
      if (slot < int'(num_slots) && slot < TOTAL_SLOTS) begin
         a = op_A[slot*ELEN +: ELEN];
         b = op_B[slot*ELEN +: ELEN];
      end
   end

   v_alu #(.LAT(UNIT_LAT)) u_alu (
      .clk  (clk),
      .nrst (nrst),
      .op   (op_alu),
      .vsew (vsew),
      .a    (a),
      .b    (b),
      .y    (res_alu)
   );

`ifdef V_LANE_SEQ_VMUL_EN
   v_mul #(.LAT(UNIT_LAT)) u_mul (
      .clk  (clk),
      .nrst (nrst),
      .op   (op_mul),
      .vsew (vsew),
      .a    (a),
      .b    (b),
      .y    (res_mul)
   );
`endif

endmodule

// File: rtl/v_lane_sequencer.sv
// v_lane_sequencer: runs one vector ALU op and one vector MUL op across a
// register group of 1, 2 or 4 registers using NUM_LANES 32-bit lanes, with a
// start/busy/done handshake.
// Ports:
//   clk, nrst                    clock, synchronous active-low reset
//   start                        request, sampled only in IDLE
//   lmul, vsew                   group size code, element width (latched)
//   op_instr_alu, op_instr_mul   opcodes (latched)
//   op_A, op_B                   operand groups, must be stable while busy
//   busy, done, err              handshake; err qualifies done (illegal lmul)
//   result_valu, result_vmul     result groups, hold until overwritten
// Build option: V_LANE_SEQ_VMUL_EN enables the multipliers; without it
// result_vmul is tied to zero and timing is unchanged.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; latches group size, opcodes and vsew
// ST_RUN   | issuing one beat per cycle, issue counter 0..B-1
// ST_DRAIN | last beat issued, waiting for the capture pipeline to empty
// ST_FIN   | done pulse (err set for an illegal lmul), back to IDLE

module v_lane_sequencer
   import v_lane_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int VLEN      = 128,
   parameter int MAX_GROUP = 4,
   parameter int UNIT_LAT  = 1
) (
   input  logic                      clk,
   input  logic                      nrst,
   input  logic                      start,
   input  logic [2:0]                lmul,
   input  logic [2:0]                vsew,
   input  logic [5:0]                op_instr_alu,
   input  logic [5:0]                op_instr_mul,
   input  logic [MAX_GROUP*VLEN-1:0] op_A,
   input  logic [MAX_GROUP*VLEN-1:0] op_B,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [MAX_GROUP*VLEN-1:0] result_valu,
   output logic [MAX_GROUP*VLEN-1:0] result_vmul
);

   localparam int TOTAL_SLOTS = MAX_GROUP * VLEN / ELEN;
   localparam int MAX_BEATS   = (TOTAL_SLOTS + NUM_LANES - 1) / NUM_LANES;
   localparam int BW          = $clog2(MAX_BEATS + 1);
   localparam int SW          = $clog2(TOTAL_SLOTS + 1);

   state_t          state_q, state_d;
   logic [BW-1:0]   cnt_q, cnt_d;
   logic [BW-1:0]   beats_q;
   logic [SW-1:0]   slots_q;
   logic [5:0]      alu_op_q;
   logic [2:0]      vsew_q;
   logic            err_q, err_d;
   logic            accept;
   logic            issue_valid;
   logic            ret_valid;
   logic [BW-1:0]   ret_beat;
   logic            drain_last;
   logic [3:0]      lmul_dec;
   logic            lmul_ok;
   logic [ELEN-1:0] lane_alu [NUM_LANES];

   assign lmul_dec = lmul_to_regs(lmul);
   assign lmul_ok  = lmul_dec[3] && (int'(lmul_dec[2:0]) <= MAX_GROUP);

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         beats_q  <= '0;
         slots_q  <= '0;
         alu_op_q <= '0;
         vsew_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         if (accept) begin
            beats_q  <= BW'(num_beats(int'(lmul_dec[2:0]), NUM_LANES, VLEN));
            slots_q  <= SW'(int'(lmul_dec[2:0]) * VLEN / ELEN);
            alu_op_q <= op_instr_alu;
            vsew_q   <= vsew;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      accept      = 1'b0;
      issue_valid = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (lmul_ok) begin
                  accept  = 1'b1;
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  state_d = ST_RUN;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_FIN;
               end
            end
         end
         ST_RUN: begin
            busy        = 1'b1;
            issue_valid = 1'b1;
            if (cnt_q == beats_q - BW'(1)) begin
               cnt_d   = '0;
               state_d = (UNIT_LAT > 0) ? ST_DRAIN : ST_FIN;
            end else begin
               cnt_d = cnt_q + BW'(1);
            end
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (drain_last) state_d = ST_FIN;
         end
         ST_FIN: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign err = done & err_q;

   // Capture pipeline: tracks which beat each unit output belongs to.
   if (UNIT_LAT == 0) begin : g_nopipe
      assign ret_valid  = issue_valid;
      assign ret_beat   = cnt_q;
      assign drain_last = 1'b1;
   end else begin : g_pipe
      logic          pipe_v [UNIT_LAT];
      logic [BW-1:0] pipe_b [UNIT_LAT];

      always_ff @(posedge clk) begin
         if (!nrst) begin
            for (int i = 0; i < UNIT_LAT; i++) begin
               pipe_v[i] <= 1'b0;
               pipe_b[i] <= '0;
            end
         end else begin
            pipe_v[0] <= issue_valid;
            pipe_b[0] <= cnt_q;
            for (int i = 1; i < UNIT_LAT; i++) begin
               pipe_v[i] <= pipe_v[i-1];
               pipe_b[i] <= pipe_b[i-1];
            end
         end
      end

      // Leave DRAIN when only the retiring stage can still be valid, so FIN
      // lines up with the cycle after the final capture.
      always_comb begin
         drain_last = 1'b1;
         for (int i = 0; i < UNIT_LAT - 1; i++) begin
            if (pipe_v[i]) drain_last = 1'b0;
         end
      end

      assign ret_valid = pipe_v[UNIT_LAT-1];
      assign ret_beat  = pipe_b[UNIT_LAT-1];
   end

`ifdef V_LANE_SEQ_VMUL_EN
   logic [5:0]      mul_op_q;
   logic [ELEN-1:0] lane_mul [NUM_LANES];

   always_ff @(posedge clk) begin
      if (!nrst)       mul_op_q <= '0;
      else if (accept) mul_op_q <= op_instr_mul;
   end
`endif

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      v_lane_slot #(
         .NUM_LANES (NUM_LANES),
         .LANE      (k),
         .VLEN      (VLEN),
         .MAX_GROUP (MAX_GROUP),
         .UNIT_LAT  (UNIT_LAT),
         .BW        (BW),
         .SW        (SW)
      ) u_slot (
         .clk       (clk),
         .nrst      (nrst),
         .beat      (cnt_q),
         .num_slots (slots_q),
         .op_alu    (alu_op_q),
         .vsew      (vsew_q),
         .op_A      (op_A),
         .op_B      (op_B),
         .res_alu   (lane_alu[k])
`ifdef V_LANE_SEQ_VMUL_EN
         ,
         .op_mul    (mul_op_q),
         .res_mul   (lane_mul[k])
`endif
      );
   end

   // Slot s belongs to beat s/NUM_LANES on lane s%NUM_LANES; slots past the
   // active group keep their previous contents.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         result_valu <= '0;
`ifdef V_LANE_SEQ_VMUL_EN
         result_vmul <= '0;
`endif
      end else if (ret_valid) begin
         for (int s = 0; s < TOTAL_SLOTS; s++) begin
            if ((s / NUM_LANES) == int'(ret_beat) && s < int'(slots_q)) begin
               result_valu[s*ELEN +: ELEN] <= lane_alu[s % NUM_LANES];
`ifdef V_LANE_SEQ_VMUL_EN
               result_vmul[s*ELEN +: ELEN] <= lane_mul[s % NUM_LANES];
`endif
            end
         end
      end
   end

`ifndef V_LANE_SEQ_VMUL_EN
   logic unused_mul_op;
   assign unused_mul_op = ^op_instr_mul;
   assign result_vmul   = '0;
`endif

endmodule

// File: tb/tb_v_lane_sequencer.sv
// Self-checking bench for v_lane_sequencer (NUM_LANES=4, VLEN=128,
// MAX_GROUP=4, UNIT_LAT=1). Directed cases followed by random ops, compared
// against a slot-level reference model. Honours V_LANE_SEQ_VMUL_EN.
module tb_v_lane_sequencer;

   localparam int NL = 4;
   localparam int VL = 128;
   localparam int MG = 4;
   localparam int UL = 1;
   localparam int NS = MG * VL / 32;

   logic            clk = 1'b0;
   logic            nrst;
   logic            start;
   logic [2:0]      lmul;
   logic [2:0]      vsew;
   logic [5:0]      op_alu;
   logic [5:0]      op_mul;
   logic [MG*VL-1:0] op_a, op_b, res_alu, res_mul;
   logic            busy, done, err;

   always #5 clk = ~clk;

   v_lane_sequencer #(
      .NUM_LANES (NL),
      .VLEN      (VL),
      .MAX_GROUP (MG),
      .UNIT_LAT  (UL)
   ) dut (
      .clk          (clk),
      .nrst         (nrst),
      .start        (start),
      .lmul         (lmul),
      .vsew         (vsew),
      .op_instr_alu (op_alu),
      .op_instr_mul (op_mul),
      .op_A         (op_a),
      .op_B         (op_b),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .result_valu  (res_alu),
      .result_vmul  (res_mul)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_alu [NS];
   logic [31:0] exp_mul [NS];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int sew_bits(input logic [2:0] sew);
      return (sew == 3'd0) ? 8 : (sew == 3'd1) ? 16 : 32;
   endfunction

   function automatic logic [31:0] m_alu(input logic [5:0] op, input logic [2:0] sew,
                                         input logic [31:0] a, input logic [31:0] b);
      longint unsigned r, mask, ea, eb;
      int w;
      w    = sew_bits(sew);
      mask = (64'd1 << w) - 64'd1;
      r    = 0;
      case (op)
         6'd0, 6'd1: begin
            for (int e = 0; e < 32 / w; e++) begin
               ea = (longint'(a) >> (e * w)) & mask;
               eb = (longint'(b) >> (e * w)) & mask;
               r  = r | ((((op == 6'd0) ? ea + eb : ea - eb) & mask) << (e * w));
            end
         end
         6'd2:    r = longint'(a & b);
         6'd3:    r = longint'(a | b);
         6'd4:    r = longint'(a ^ b);
         default: r = longint'(a);
      endcase
      return r[31:0];
   endfunction

   function automatic logic [31:0] m_mul(input logic [5:0] op, input logic [2:0] sew,
                                         input logic [31:0] a, input logic [31:0] b);
      longint unsigned r, mask, ea, eb;
      int w;
      w    = sew_bits(sew);
      mask = (64'd1 << w) - 64'd1;
      r    = 0;
      if (op == 6'd0) begin
         for (int e = 0; e < 32 / w; e++) begin
            ea = (longint'(a) >> (e * w)) & mask;
            eb = (longint'(b) >> (e * w)) & mask;
            r  = r | (((ea * eb) & mask) << (e * w));
         end
      end else if (op == 6'd1) begin
         r = (longint'(a) * longint'(b)) >> 32;
      end
      return r[31:0];
   endfunction

   task automatic check_results(input string tag);
      logic [31:0] ga, gm;
      for (int s = 0; s < NS; s++) begin
         ga = res_alu[s*32 +: 32];
         gm = res_mul[s*32 +: 32];
         check($sformatf("%s alu[%0d]", tag, s), ga, exp_alu[s]);
         check($sformatf("%s mul[%0d]", tag, s), gm, exp_mul[s]);
      end
   endtask

   // Issues one op and checks busy/done/err every cycle up to the done cycle,
   // then the result buses and that done does not repeat.
   task automatic run_op(input logic [2:0] lm, input logic [5:0] aop, input logic [5:0] mop,
                         input logic [2:0] sew, input bit junk);
      int  regs, s_cnt, beats, done_cyc;
      bit  legal;
      legal    = (lm <= 3'd2);
      regs     = legal ? (1 << lm) : 0;
      s_cnt    = regs * VL / 32;
      beats    = (s_cnt + NL - 1) / NL;
      done_cyc = legal ? beats + UL + 1 : 1;

      @(negedge clk);
      start  = 1'b1;
      lmul   = lm;
      op_alu = aop;
      op_mul = mop;
      vsew   = sew;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 1; c <= done_cyc; c++) begin
         check($sformatf("busy c%0d", c), busy, (c < done_cyc) ? 1 : 0);
         check($sformatf("done c%0d", c), done, (c == done_cyc) ? 1 : 0);
         if (c == done_cyc) check("err", err, legal ? 0 : 1);
         if (c < done_cyc) begin
            if (junk) begin
               start  = 1'($urandom_range(0, 1));
               lmul   = 3'($urandom);
               op_alu = 6'($urandom);
               op_mul = 6'($urandom);
               vsew   = 3'($urandom);
            end
            @(posedge clk);
            #1;
         end
      end
      start = 1'b0;

      for (int s = 0; s < s_cnt; s++) begin
         exp_alu[s] = m_alu(aop, sew, op_a[s*32 +: 32], op_b[s*32 +: 32]);
`ifdef V_LANE_SEQ_VMUL_EN
         exp_mul[s] = m_mul(mop, sew, op_a[s*32 +: 32], op_b[s*32 +: 32]);
`endif
      end
      check_results("op");

      @(posedge clk);
      #1;
      check("done_once", done, 0);
      check("idle_busy", busy, 0);
   endtask

   task automatic rand_operands();
      for (int w = 0; w < NS; w++) begin
         op_a[w*32 +: 32] = $urandom;
         op_b[w*32 +: 32] = $urandom;
      end
   endtask

   initial begin
      nrst   = 1'b0;
      start  = 1'b0;
      lmul   = '0;
      vsew   = '0;
      op_alu = '0;
      op_mul = '0;
      op_a   = '0;
      op_b   = '0;
      for (int s = 0; s < NS; s++) begin
         exp_alu[s] = '0;
         exp_mul[s] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst err", err, 0);
      check_results("reset");
      @(negedge clk);
      nrst = 1'b1;

      // Four-register add: slot i = i + 1, done in cycle 6.
      for (int s = 0; s < NS; s++) begin
         op_a[s*32 +: 32] = s;
         op_b[s*32 +: 32] = 1;
      end
      run_op(3'd2, 6'd0, 6'd0, 3'd2, 1'b0);
      for (int s = 0; s < NS; s++) check($sformatf("add slot%0d", s), res_alu[s*32 +: 32], s + 1);

      // Single register multiply of 3 x 5; upper slots untouched.
      for (int s = 0; s < NS; s++) begin
         op_a[s*32 +: 32] = 3;
         op_b[s*32 +: 32] = 5;
      end
      run_op(3'd0, 6'd5, 6'd0, 3'd2, 1'b0);

      // Two-register op with start and controls toggled while busy.
      rand_operands();
      run_op(3'd1, 6'd4, 6'd1, 3'd2, 1'b1);

      // Illegal group sizes.
      rand_operands();
      run_op(3'd3, 6'd0, 6'd0, 3'd0, 1'b0);
      run_op(3'd7, 6'd1, 6'd0, 3'd1, 1'b0);

      for (int n = 0; n < 30; n++) begin
         rand_operands();
         run_op(3'($urandom_range(0, 4)), 6'($urandom_range(0, 6)), 6'($urandom_range(0, 2)),
                3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      // Reset during cycle 3 of a four-beat op aborts it without a done pulse.
      rand_operands();
      @(negedge clk);
      start  = 1'b1;
      lmul   = 3'd2;
      op_alu = 6'd0;
      op_mul = 6'd0;
      vsew   = 3'd2;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("pre-rst busy", busy, 1);
      nrst = 1'b0;
      @(posedge clk);
      #1;
      check("midrst busy", busy, 0);
      check("midrst done", done, 0);
      check("midrst err", err, 0);
      for (int s = 0; s < NS; s++) begin
         exp_alu[s] = '0;
         exp_mul[s] = '0;
      end
      check_results("midrst");
      @(negedge clk);
      nrst = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         check("post-rst done", done, 0);
      end

      rand_operands();
      run_op(3'd2, 6'd1, 6'd0, 3'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
